// File: rtl/umi_gpio_arbiter_pkg.sv
// Shared UMI opcodes, owner index type and helpers for the GPIO device-port arbiter.
package umi_gpio_arbiter_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  // Wide enough for any practical host count; unused upper bits stay zero.
  localparam int OWNER_W = 8;
  typedef logic [OWNER_W-1:0] owner_t;

  function automatic logic is_posted(input logic [4:0] opcode);
    return opcode == UMI_REQ_POSTED;
  endfunction

endpackage

// File: rtl/umi_owner_fifo.sv
// Records which host issued each outstanding non-posted request, oldest at the head.
module umi_owner_fifo
  import umi_gpio_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic                     pop,
  input  owner_t                   din,
  output owner_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  owner_t          mem_q [DEPTH];
  owner_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = cnt_q == (PW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/umi_gpio_arbiter.sv
// Round-robin share of one UMI device port among NREQ hosts; responses are steered
// back to the issuing host through an in-order owner FIFO.
module umi_gpio_arbiter
  import umi_gpio_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [NREQ-1:0]           host_req_valid,
  output logic [NREQ-1:0]           host_req_ready,
  input  logic [NREQ*CW-1:0]        host_req_cmd,
  input  logic [NREQ*AW-1:0]        host_req_dstaddr,
  input  logic [NREQ*AW-1:0]        host_req_srcaddr,
  input  logic [NREQ*DW-1:0]        host_req_data,
  output logic [NREQ-1:0]           host_resp_valid,
  input  logic [NREQ-1:0]           host_resp_ready,
  output logic [NREQ*CW-1:0]        host_resp_cmd,
  output logic [NREQ*AW-1:0]        host_resp_dstaddr,
  output logic [NREQ*AW-1:0]        host_resp_srcaddr,
  output logic [NREQ*DW-1:0]        host_resp_data,
  output logic                      udev_req_valid,
  input  logic                      udev_req_ready,
  output logic [CW-1:0]             udev_req_cmd,
  output logic [AW-1:0]             udev_req_dstaddr,
  output logic [AW-1:0]             udev_req_srcaddr,
  output logic [DW-1:0]             udev_req_data,
  input  logic                      udev_resp_valid,
  output logic                      udev_resp_ready,
  input  logic [CW-1:0]             udev_resp_cmd,
  input  logic [AW-1:0]             udev_resp_dstaddr,
  input  logic [AW-1:0]             udev_resp_srcaddr,
  input  logic [DW-1:0]             udev_resp_data,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err_orphan
);
  localparam int GW = $clog2(NREQ);

  logic [GW-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, grant;
  logic            locked_q, locked_d, err_orphan_q, err_orphan_d;
  logic [NREQ-1:0] elig;
  logic            found, req_hs, push, pop, full, empty, resp_sel_rdy;
  owner_t          head;
  int              idx;

  umi_owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .pop    (pop),
    .din    (owner_t'(grant)),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (outstanding)
  );

  // Full FIFO blocks non-posted requests even if a pop lands the same cycle,
  // so eligibility never depends on the response path.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    grant = rr_ptr_q;
    idx   = 0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = host_req_valid[i] && (is_posted(host_req_cmd[i*CW +: 5]) || !full);
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = GW'(idx);
      end
    end
    if (locked_q) begin
      grant = grant_q;
      found = host_req_valid[grant_q];
    end
  end

  assign udev_req_valid   = nreset && found;
  assign udev_req_cmd     = host_req_cmd[int'(grant)*CW +: CW];
  assign udev_req_dstaddr = host_req_dstaddr[int'(grant)*AW +: AW];
  assign udev_req_srcaddr = host_req_srcaddr[int'(grant)*AW +: AW];
  assign udev_req_data    = host_req_data[int'(grant)*DW +: DW];
  assign req_hs           = udev_req_valid && udev_req_ready;
  assign push             = req_hs && !is_posted(udev_req_cmd[4:0]);

  always_comb begin
    host_req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      host_req_ready[i] = req_hs && (grant == GW'(i));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    locked_d = locked_q;
    grant_d  = grant_q;
    if (req_hs) begin
      rr_ptr_d = (grant == GW'(NREQ-1)) ? '0 : grant + 1'b1;
      locked_d = 1'b0;
    end else if (udev_req_valid) begin
      locked_d = 1'b1;
      grant_d  = grant;
    end
  end

  always_comb begin
    resp_sel_rdy    = 1'b0;
    host_resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head == owner_t'(i)) resp_sel_rdy = host_resp_ready[i];
      host_resp_valid[i] = nreset && !empty && udev_resp_valid && (head == owner_t'(i));
    end
  end

  // With no owner on record the response is swallowed and flagged.
  assign udev_resp_ready   = nreset && (empty || resp_sel_rdy);
  assign pop               = nreset && !empty && udev_resp_valid && resp_sel_rdy;
  assign err_orphan_d      = err_orphan_q || (empty && udev_resp_valid);
  assign err_orphan        = err_orphan_q;
  assign host_resp_cmd     = {NREQ{udev_resp_cmd}};
  assign host_resp_dstaddr = {NREQ{udev_resp_dstaddr}};
  assign host_resp_srcaddr = {NREQ{udev_resp_srcaddr}};
  assign host_resp_data    = {NREQ{udev_resp_data}};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      locked_q     <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      locked_q     <= locked_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule
